// File: rtl/sync_dff_pkg.sv
// sync_dff_pkg: shared widths and reset-value helper for the synchronous_dff chain
package sync_dff_pkg;
  localparam int SYNC_DFF_DEFAULT_WIDTH = 1;
  localparam int SYNC_DFF_MAX_WIDTH = 64;
  function automatic logic [SYNC_DFF_MAX_WIDTH-1:0] sync_dff_zero(input int width);
    sync_dff_zero = '0;
    for (int i = 0; i < width && i < SYNC_DFF_MAX_WIDTH; i++) sync_dff_zero[i] = 1'b0;
  endfunction
endpackage

// File: rtl/dff_stage.sv
// dff_stage: one WIDTH-bit register with synchronous reset to RST_VAL and load enable
module dff_stage
  import sync_dff_pkg::*;
#(
  parameter int WIDTH = SYNC_DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(sync_dff_zero(WIDTH))
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = en_i ? d_i : q_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= RST_VAL;
    else q_q <= q_d;
  end
  assign q_o = q_q;
endmodule

// File: rtl/synchronous_dff.sv
// synchronous_dff: two-stage D flop chain (Q1 = D delayed 1, Q2 = D delayed 2), sync active-high reset
// Optional clock enable CE is compiled in when SYNC_DFF_CE_EN is defined.
module synchronous_dff
  import sync_dff_pkg::*;
#(
  parameter int WIDTH = SYNC_DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(sync_dff_zero(WIDTH))
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef SYNC_DFF_CE_EN
  input  logic             CE,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2
);
  logic en;
`ifdef SYNC_DFF_CE_EN
  assign en = CE;
`else
  assign en = 1'b1;
`endif
  if (WIDTH < 1 || WIDTH > SYNC_DFF_MAX_WIDTH) begin : g_bad_width
    $error("synchronous_dff: WIDTH %0d outside 1..%0d", WIDTH, SYNC_DFF_MAX_WIDTH);
  end
  dff_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_s1 (
    .clk_i(CLK), .rst_i(RST), .en_i(en), .d_i(D), .q_o(Q1)
  );
  dff_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_s2 (
    .clk_i(CLK), .rst_i(RST), .en_i(en), .d_i(Q1), .q_o(Q2)
  );
endmodule

// File: tb/tb_synchronous_dff.sv
// tb_synchronous_dff: directed and random checks of synchronous_dff against a two-entry delay-line model
module tb_synchronous_dff;
  localparam logic [7:0] RV = 8'hA5;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [7:0] d = '0;
  logic [7:0] q1_8, q2_8;
  logic q1_1, q2_1;
`ifdef SYNC_DFF_CE_EN
  logic ce = 1'b1;
`endif
  int errors = 0, checks = 0;
  logic [7:0] m8[$];
  logic m1[$];

  synchronous_dff #(.WIDTH(8), .RST_VAL(RV)) dut8 (
    .CLK(clk), .RST(rst),
`ifdef SYNC_DFF_CE_EN
    .CE(ce),
`endif
    .D(d), .Q1(q1_8), .Q2(q2_8)
  );
  synchronous_dff dut1 (
    .CLK(clk), .RST(rst),
`ifdef SYNC_DFF_CE_EN
    .CE(ce),
`endif
    .D(d[0]), .Q1(q1_1), .Q2(q2_1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("q1_w8", q1_8, m8[0]);
    chk("q2_w8", q2_8, m8[1]);
    chk("q1_w1", {7'b0, q1_1}, {7'b0, m1[0]});
    chk("q2_w1", {7'b0, q2_1}, {7'b0, m1[1]});
  endtask

  // Model: each output stage is a slot in a 2-deep delay line; reset refills both slots.
  task automatic step(input logic [7:0] dv, input logic r, input logic c);
    @(negedge clk);
    d = dv;
    rst = r;
`ifdef SYNC_DFF_CE_EN
    ce = c;
`endif
    @(posedge clk);
    if (r) begin
      m8 = '{RV, RV};
      m1 = '{1'b0, 1'b0};
    end else if (c) begin
      m8.push_front(dv);
      void'(m8.pop_back());
      m1.push_front(dv[0]);
      void'(m1.pop_back());
    end
    #1 check_all();
  endtask

  initial begin
    m8 = '{8'h00, 8'h00};
    m1 = '{1'b0, 1'b0};
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    step(8'h01, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    repeat (3) step(8'hFF, 1'b0, 1'b1);
    step(8'hFF, 1'b1, 1'b1);
    repeat (3) step(8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #0 check_all();
    step(8'h3C, 1'b0, 1'b1);
    step(8'h3C, 1'b0, 1'b1);
    step(8'h3C, 1'b0, 1'b1);
`ifdef SYNC_DFF_CE_EN
    step(8'h11, 1'b0, 1'b1);
    step(8'h22, 1'b0, 1'b0);
    step(8'h33, 1'b0, 1'b0);
    step(8'h44, 1'b1, 1'b0);
    step(8'h55, 1'b0, 1'b0);
    step(8'h66, 1'b0, 1'b1);
`endif
    repeat (150) begin
`ifdef SYNC_DFF_CE_EN
      step(8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
`else
      step(8'($urandom), $urandom_range(0, 9) == 0, 1'b1);
`endif
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
